matvec_sequencer: RTL and testbench
===================================

Name: matvec_sequencer

Overview:
Controller that sequences the matrix-vector multiply datapath in the RISCV CPU. It walks the column-major matrix memory and the vector memory, accumulates each row's dot product, and writes each result word to OUTRAM. It raises done and reports the total cycle count to the top-level clock_count output. It replaces the hand-coded loop that drives the MAC path.

Parameters:
ROWS, 3, number of matrix rows (>=1)
COLS, 4, number of matrix columns and vector length (>=1)
DATA_W, 32, signed data width of matrix, vector and result
ADDR_W, 10, address width of matrix memory (ROWS*COLS <= 2**ADDR_W)
MAT_BASE, 0, word offset of element (0,0) in matrix memory

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
start  in  1  begin a run; sampled only when not busy
busy  out  1  high from the cycle after start is accepted until the last OUTRAM write completes
done  out  1  sticky completion flag; cleared when start is accepted
clock_count  out  32  cycles spent busy in the current or last run
mat_rd_en  out  1  matrix memory read strobe
mat_addr  out  ADDR_W  MAT_BASE + i + j*ROWS (column-major)
mat_rdata  in  DATA_W  matrix read data, valid 1 cycle after mat_rd_en
vec_rd_en  out  1  vector memory read strobe
vec_addr  out  clog2(COLS)  j
vec_rdata  in  DATA_W  vector read data, valid 1 cycle after vec_rd_en
out_we  out  1  OUTRAM write enable, one-cycle pulse
out_addr  out  clog2(ROWS)  row index i
out_wdata  out  DATA_W  row dot product

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; counters i, j and acc at 0.
- FSM states: IDLE, FETCH, MAC, WRITE.
- IDLE:
  - start=1 -> FETCH.
  - On that transition: i=0, j=0, acc=0, clock_count=0, done=0.
- FETCH:
  - Assert mat_rd_en and vec_rd_en with the addresses for (i,j).
  - Next state is MAC.
- MAC:
  - Compute acc <= acc + low DATA_W bits of signed(mat_rdata)*signed(vec_rdata).
  - Arithmetic is two's-complement and wraps; there is no saturation.
  - If j==COLS-1 -> WRITE; otherwise j++ and -> FETCH.
- WRITE:
  - out_we=1, out_addr=i, out_wdata=acc, where acc includes the last MAC.
  - Then acc=0 and j=0.
  - If i==ROWS-1 -> IDLE with done=1; otherwise i++ and -> FETCH.
- Latency:
  - Each row takes 2*COLS+1 cycles; a full run takes ROWS*(2*COLS+1) cycles.
  - For the defaults, 27 cycles.
- clock_count:
  - Increments on every cycle spent in FETCH, MAC or WRITE.
  - Frozen in IDLE and held until the next accepted start.
  - Wraps at 2**32.
- busy: high exactly in FETCH, MAC and WRITE.
- done:
  - Set on the WRITE->IDLE edge, so it rises in the same cycle busy falls.
  - Stays high until the next accepted start; start in IDLE with done=1 restarts immediately.
- Start while busy: ignored, with no effect on state or counters.
- Reset mid-run:
  - Returns to IDLE with all outputs 0 on the next edge.
  - No further OUTRAM writes occur; partial OUTRAM contents are left as they are.
- Read strobes are high only in FETCH; out_we is high only in WRITE.

Decomposition:
- Shared package riscv_pkg holds:
  - the FSM state typedef (seq_state_t: IDLE, FETCH, MAC, WRITE);
  - the DATA_W default;
  - the clog2 helper function.
- One natural sub-module is matvec_mac: a registered signed multiply-accumulate.
  - Ports: clear, en, a, b, acc.
  - The FSM drives clear in WRITE and en in MAC.

Test Plan:
- Default 3x4 case.
  - Stimulus: matrix memory word k holds k+1 (k=0..11), vector = [1,2,3,4], pulse start.
  - Required: OUTRAM = [70,80,90], three out_we pulses, done rises with busy falling, clock_count=27.
- Signed case.
  - Stimulus: matrix all -1, vector all 2.
  - Required: OUTRAM = [-8,-8,-8].
- Wrap case.
  - Stimulus: every matrix word 0x7FFFFFFF, vector all 2.
  - Required: each product is 0xFFFFFFFE and each result is 0xFFFFFFF8.
- Start while busy.
  - Stimulus: extra start pulses at cycles 5 and 12 of a run.
  - Required: results and clock_count=27 unchanged; exactly 3 writes.
- Reset mid-run.
  - Stimulus: assert rst in cycle 10, i.e. during row 1.
  - Required:
    - next cycle busy=0, done=0, clock_count=0, no out_we after the reset;
    - a following start produces the correct full results.
- Back-to-back runs.
  - Stimulus: start in the cycle after done rises, with a new vector [0,0,0,1].
  - Required:
    - done clears on acceptance and clock_count restarts from 0;
    - OUTRAM = [10,11,12];
    - clock_count=27 at the second done.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the matrix-vector multiply path: sequencer state
// encoding, default data width and a width helper for index counters.
package riscv_pkg;

  // Sequencer states. IDLE is encoded as 0 so a cleared state register is idle.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    MAC   = 2'd2,
    WRITE = 2'd3
  } seq_state_t;

  localparam int DATA_W_DEF = 32;

  // Number of bits needed to index n items. Never returns less than 1, so a
  // single-row or single-column build still gets a legal one-bit counter.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int k = 1; k < 32; k++) begin
      if ((1 << k) < n) r = k + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/matvec_mac.sv
// Registered signed multiply-accumulate. Only the low DATA_W bits of each
// product are added; two's-complement arithmetic wraps with no saturation.
module matvec_mac
  import riscv_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] acc
);

  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] w_prod;

  // The low DATA_W bits of a product are identical for signed and unsigned
  // operands, so a DATA_W-wide multiply gives the wrapped signed product.
  assign w_prod = a * b;

  // Accumulator: clear has priority over accumulate.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_acc <= '0;
    end else if (en) begin
      r_acc <= r_acc + w_prod;
    end
  end

  assign acc = r_acc;

endmodule

// File: rtl/matvec_sequencer.sv
// Sequencer for the matrix-vector multiply. Walks a column-major matrix
// memory and a vector memory, accumulates one dot product per row and writes
// each result to OUTRAM. Each row costs FETCH/MAC per column plus one WRITE.
//
// Handshake: there is no valid/ready pair. start is a level sampled only in
// IDLE; while busy it is ignored. Memory reads are fire-and-forget: data is
// expected on the *_rdata inputs exactly one cycle after the strobe, and
// out_we is a single-cycle write pulse with no back-pressure.
module matvec_sequencer
  import riscv_pkg::*;
#(
  parameter int ROWS     = 3,
  parameter int COLS     = 4,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = 10,
  parameter int MAT_BASE = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [31:0]              clock_count,
  output logic                     mat_rd_en,
  output logic [ADDR_W-1:0]        mat_addr,
  input  logic [DATA_W-1:0]        mat_rdata,
  output logic                     vec_rd_en,
  output logic [clog2(COLS)-1:0]   vec_addr,
  input  logic [DATA_W-1:0]        vec_rdata,
  output logic                     out_we,
  output logic [clog2(ROWS)-1:0]   out_addr,
  output logic [DATA_W-1:0]        out_wdata,
  output logic [1:0]               dbg_state
);

  localparam int IW = clog2(ROWS);
  localparam int JW = clog2(COLS);

  seq_state_t        r_state;
  seq_state_t        w_next;
  logic [IW-1:0]     r_i;
  logic [JW-1:0]     r_j;
  logic [31:0]       r_count;
  logic              r_done;

  logic              w_accept;
  logic              w_last_col;
  logic              w_last_row;
  logic              w_mac_en;
  logic              w_mac_clear;
  logic [DATA_W-1:0] w_acc;
  logic [ADDR_W-1:0] w_elem_addr;

  assign w_accept   = (r_state == IDLE) && start;
  assign w_last_col = (r_j == JW'(COLS - 1));
  assign w_last_row = (r_i == IW'(ROWS - 1));

  // Column-major element address for (i, j).
  assign w_elem_addr = ADDR_W'(MAT_BASE) + ADDR_W'(r_i) + ADDR_W'(r_j) * ADDR_W'(ROWS);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic and registered-state-decoded outputs.
  always_comb begin
    w_next      = r_state;
    busy        = 1'b0;
    mat_rd_en   = 1'b0;
    vec_rd_en   = 1'b0;
    mat_addr    = '0;
    vec_addr    = '0;
    out_we      = 1'b0;
    out_addr    = '0;
    out_wdata   = '0;
    w_mac_en    = 1'b0;
    w_mac_clear = w_accept;
    case (r_state)
      IDLE: begin
        if (start) w_next = FETCH;
      end
      FETCH: begin
        busy      = 1'b1;
        mat_rd_en = 1'b1;
        vec_rd_en = 1'b1;
        mat_addr  = w_elem_addr;
        vec_addr  = r_j;
        w_next    = MAC;
      end
      MAC: begin
        busy     = 1'b1;
        w_mac_en = 1'b1;
        w_next   = w_last_col ? WRITE : FETCH;
      end
      WRITE: begin
        busy        = 1'b1;
        out_we      = 1'b1;
        out_addr    = r_i;
        out_wdata   = w_acc;
        w_mac_clear = 1'b1;
        w_next      = w_last_row ? IDLE : FETCH;
      end
      default: w_next = IDLE;
    endcase
  end

  // Row/column counters, busy-cycle counter and sticky done flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_i     <= '0;
      r_j     <= '0;
      r_count <= '0;
      r_done  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_i     <= '0;
        r_j     <= '0;
        r_count <= '0;
        r_done  <= 1'b0;
      end else if (r_state != IDLE) begin
        r_count <= r_count + 32'd1;
      end
      if (r_state == MAC && !w_last_col) begin
        r_j <= r_j + JW'(1);
      end
      if (r_state == WRITE) begin
        r_j <= '0;
        if (w_last_row) begin
          r_done <= 1'b1;
        end else begin
          r_i <= r_i + IW'(1);
        end
      end
    end
  end

  matvec_mac #(
    .DATA_W (DATA_W)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .clear (w_mac_clear),
    .en    (w_mac_en),
    .a     (mat_rdata),
    .b     (vec_rdata),
    .acc   (w_acc)
  );

  assign done        = r_done;
  assign clock_count = r_count;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_matvec_sequencer.sv
// Self-checking bench for matvec_sequencer (default 3x4, 32-bit).
module tb_matvec_sequencer;

  localparam int ROWS    = 3;
  localparam int COLS    = 4;
  localparam int DW      = 32;
  localparam int RUN_CYC = ROWS * (2 * COLS + 1);

  typedef struct {
    logic [DW-1:0] mat [ROWS*COLS];
    logic [DW-1:0] vec [COLS];
    logic [DW-1:0] exp [ROWS];
  } vec_rec_t;

  logic          clk;
  logic          rst;
  logic          start;
  logic          busy;
  logic          done;
  logic [31:0]   clock_count;
  logic          mat_rd_en;
  logic [9:0]    mat_addr;
  logic [DW-1:0] mat_rdata;
  logic          vec_rd_en;
  logic [1:0]    vec_addr;
  logic [DW-1:0] vec_rdata;
  logic          out_we;
  logic [1:0]    out_addr;
  logic [DW-1:0] out_wdata;
  logic [1:0]    dbg_state;

  logic [DW-1:0] mat_mem [ROWS*COLS];
  logic [DW-1:0] vec_mem [COLS];
  logic [33:0]   exp_q [$];
  vec_rec_t      tbl [4];
  int            checks;
  int            errors;
  int            wr_count;

  matvec_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .clock_count (clock_count),
    .mat_rd_en   (mat_rd_en),
    .mat_addr    (mat_addr),
    .mat_rdata   (mat_rdata),
    .vec_rd_en   (vec_rd_en),
    .vec_addr    (vec_addr),
    .vec_rdata   (vec_rdata),
    .out_we      (out_we),
    .out_addr    (out_addr),
    .out_wdata   (out_wdata),
    .dbg_state   (dbg_state)
  );

  // Clock and reset-time defaults.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous memory models: data one cycle after the strobe.
  always @(posedge clk) begin
    if (mat_rd_en) mat_rdata <= mat_mem[int'(mat_addr)];
    if (vec_rd_en) vec_rdata <= vec_mem[int'(vec_addr)];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Scoreboard: every OUTRAM write must match the head of the expected queue.
  always @(negedge clk) begin
    if (out_we) begin
      wr_count++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual=%0d:%0h required=none", out_addr, out_wdata);
      end else begin
        check("out_write", 64'({out_addr, out_wdata}), 64'(exp_q.pop_front()));
      end
    end
  end

  // Run one table entry from start to done. Inputs change just after negedge.
  task automatic run_case(input int idx, input bit extra);
    int cyc;
    bit prev_busy;
    bit seen;
    for (int k = 0; k < ROWS * COLS; k++) mat_mem[k] = tbl[idx].mat[k];
    for (int k = 0; k < COLS; k++) vec_mem[k] = tbl[idx].vec[k];
    for (int r = 0; r < ROWS; r++) exp_q.push_back({2'(r), tbl[idx].exp[r]});
    wr_count = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("accept_busy", 64'(busy), 64'(1));
    check("accept_done_clear", 64'(done), 64'(0));
    check("accept_count_zero", 64'(clock_count), 64'(0));
    cyc = 1;
    prev_busy = 1'b1;
    seen = 1'b0;
    while (cyc < 200 && !seen) begin
      start = extra && (cyc == 5 || cyc == 12);
      @(negedge clk);
      cyc++;
      if (done) seen = 1'b1;
      else prev_busy = busy;
    end
    start = 1'b0;
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=no_done required=done case=%0d", idx);
    end else begin
      check("done_with_busy_fall", 64'({prev_busy, busy}), 64'(2'b10));
      check("clock_count_run", 64'(clock_count), 64'(RUN_CYC));
      check("write_count", 64'(wr_count), 64'(ROWS));
      check("queue_drained", 64'(exp_q.size()), 64'(0));
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    wr_count = 0;
    rst      = 1'b1;
    start    = 1'b0;

    // Table: default, signed, wrap, back-to-back second vector.
    for (int k = 0; k < ROWS * COLS; k++) begin
      tbl[0].mat[k] = DW'(k + 1);
      tbl[1].mat[k] = 32'hFFFF_FFFF;
      tbl[2].mat[k] = 32'h7FFF_FFFF;
      tbl[3].mat[k] = DW'(k + 1);
    end
    for (int k = 0; k < COLS; k++) begin
      tbl[0].vec[k] = DW'(k + 1);
      tbl[1].vec[k] = 32'd2;
      tbl[2].vec[k] = 32'd2;
      tbl[3].vec[k] = (k == COLS - 1) ? 32'd1 : 32'd0;
    end
    tbl[0].exp[0] = 32'd70;
    tbl[0].exp[1] = 32'd80;
    tbl[0].exp[2] = 32'd90;
    for (int r = 0; r < ROWS; r++) begin
      tbl[1].exp[r] = 32'hFFFF_FFF8;
      tbl[2].exp[r] = 32'hFFFF_FFF8;
    end
    tbl[3].exp[0] = 32'd10;
    tbl[3].exp[1] = 32'd11;
    tbl[3].exp[2] = 32'd12;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_count", 64'(clock_count), 64'(0));
    check("rst_rd_en", 64'({mat_rd_en, vec_rd_en}), 64'(0));
    check("rst_out", 64'({out_we, out_addr, out_wdata}), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // Table-driven runs, issued back to back.
    for (int idx = 0; idx < 3; idx++) run_case(idx, 1'b0);

    // Idle hold: done sticky, count frozen, strobes quiet.
    repeat (3) @(negedge clk);
    check("idle_done_held", 64'(done), 64'(1));
    check("idle_count_frozen", 64'(clock_count), 64'(RUN_CYC));
    check("idle_quiet", 64'({busy, mat_rd_en, vec_rd_en, out_we}), 64'(0));

    // Start pulses while busy must be ignored.
    run_case(0, 1'b1);

    // Reset during row 1.
    for (int k = 0; k < ROWS * COLS; k++) mat_mem[k] = tbl[0].mat[k];
    for (int k = 0; k < COLS; k++) vec_mem[k] = tbl[0].vec[k];
    for (int r = 0; r < ROWS; r++) exp_q.push_back({2'(r), tbl[0].exp[r]});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("midrun_row0_written", 64'(exp_q.size()), 64'(ROWS - 1));
    exp_q.delete();
    rst = 1'b1;
    @(negedge clk);
    check("midrun_rst_busy", 64'(busy), 64'(0));
    check("midrun_rst_done", 64'(done), 64'(0));
    check("midrun_rst_count", 64'(clock_count), 64'(0));
    check("midrun_rst_out_we", 64'(out_we), 64'(0));
    rst = 1'b0;
    repeat (12) @(negedge clk);
    run_case(0, 1'b0);

    // Back-to-back: restart the cycle after done with a new vector.
    run_case(3, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
